// File: rtl/regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl
//   Scoreboard and write-port arbiter for the register file in the
//   register-read stage. It keeps one busy bit per register and stalls issue
//   on RAW/WAW hazards. It arbitrates the ALU and load write-back requesters
//   onto the single write port, using starvation-protected mem-first
//   priority, and drives that write port from registers.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   flush             : squashes the instruction presented at issue this cycle
//   iss_*             : issue request (sources, destination) / iss_ready grant
//   wb_alu_*          : ALU write-back request, wb_alu_ready grant
//   wb_mem_*          : load write-back request, wb_mem_ready grant
//   rf_we/waddr/wdata : registered register-file write port
//   busy              : registered outstanding-write bit per register
//   err_spurious      : sticky flag, a commit hit a register that was not busy
// ---------------------------------------------------------------------------
module regfile_access_ctrl #(
  parameter int NREG         = 8,
  parameter int AW           = 3,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_src_a,
  input  logic            iss_use_a,
  input  logic [AW-1:0]   iss_src_b,
  input  logic            iss_use_b,
  input  logic [AW-1:0]   iss_dst,
  input  logic            iss_wr,
  output logic            iss_ready,
  input  logic            wb_alu_valid,
  input  logic [AW-1:0]   wb_alu_addr,
  input  logic [DW-1:0]   wb_alu_data,
  output logic            wb_alu_ready,
  input  logic            wb_mem_valid,
  input  logic [AW-1:0]   wb_mem_addr,
  input  logic [DW-1:0]   wb_mem_data,
  output logic            wb_mem_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic [NREG-1:0] busy,
  output logic            err_spurious
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  logic [NREG-1:0] busy_r;
  logic            rf_we_r;
  logic [AW-1:0]   rf_waddr_r;
  logic [DW-1:0]   rf_wdata_r;
  logic            err_r;
  logic [SCW-1:0]  starve_r;

  logic            hazard_s;
  logic            iss_ready_s;
  logic            alu_force_s;
  logic            alu_grant_s;
  logic            mem_grant_s;
  logic            grant_s;
  logic [AW-1:0]   grant_addr_s;
  logic [DW-1:0]   grant_data_s;
  logic [SCW-1:0]  starve_nxt_s;
  logic [NREG-1:0] busy_nxt_s;
  logic            err_nxt_s;

  // Issue hazard check against the registered busy vector (no bypass).
  always_comb begin
    hazard_s    = 1'b0;
    iss_ready_s = 1'b0;
    hazard_s = (iss_use_a & busy_r[iss_src_a]) |
               (iss_use_b & busy_r[iss_src_b]) |
               (iss_wr    & busy_r[iss_dst]);
    if (reset) begin
      iss_ready_s = 1'b0;
    end else begin
      iss_ready_s = iss_valid & ~flush & ~hazard_s;
    end
  end

  // Write-port arbitration: mem first unless the ALU has hit its starve limit.
  always_comb begin
    alu_force_s  = 1'b0;
    alu_grant_s  = 1'b0;
    mem_grant_s  = 1'b0;
    grant_addr_s = wb_mem_addr;
    grant_data_s = wb_mem_data;
    if (reset) begin
      alu_grant_s = 1'b0;
      mem_grant_s = 1'b0;
    end else begin
      alu_force_s = wb_alu_valid & (starve_r == STARVE_MAX);
      alu_grant_s = wb_alu_valid & (alu_force_s | ~wb_mem_valid);
      mem_grant_s = wb_mem_valid & ~alu_grant_s;
    end
    if (alu_grant_s) begin
      grant_addr_s = wb_alu_addr;
      grant_data_s = wb_alu_data;
    end else begin
      grant_addr_s = wb_mem_addr;
      grant_data_s = wb_mem_data;
    end
    grant_s = alu_grant_s | mem_grant_s;
  end

  // Starvation counter: counts consecutive cycles the ALU asked and lost.
  always_comb begin
    starve_nxt_s = starve_r;
    if (!wb_alu_valid || alu_grant_s) begin
      starve_nxt_s = {SCW{1'b0}};
    end else begin
      starve_nxt_s = starve_r + SCW'(1);
    end
  end

  // Busy/error update: the commit clears first, so a same-edge issue set wins.
  always_comb begin
    busy_nxt_s = busy_r;
    err_nxt_s  = err_r;
    if (rf_we_r) begin
      if (!busy_r[rf_waddr_r]) begin
        err_nxt_s = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
      busy_nxt_s[rf_waddr_r] = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
    if (iss_ready_s && iss_wr) begin
      busy_nxt_s[iss_dst] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // State registers: scoreboard, error flag, starve counter, write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= {NREG{1'b0}};
      err_r      <= 1'b0;
      starve_r   <= {SCW{1'b0}};
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {AW{1'b0}};
      rf_wdata_r <= {DW{1'b0}};
    end else begin
      busy_r   <= busy_nxt_s;
      err_r    <= err_nxt_s;
      starve_r <= starve_nxt_s;
      rf_we_r  <= grant_s;
      if (grant_s) begin
        rf_waddr_r <= grant_addr_s;
        rf_wdata_r <= grant_data_s;
      end
    end
  end

  assign iss_ready    = iss_ready_s;
  assign wb_alu_ready = alu_grant_s;
  assign wb_mem_ready = mem_grant_s;
  assign rf_we        = rf_we_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign busy         = busy_r;
  assign err_spurious = err_r;

endmodule
